lag_filter_sched: RTL
=====================

LAG_FILTER_SCHED -- requirements
Module: lag_filter_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, sample width (signed).
REQ-002 The block SHALL have parameter COEFFICIENT_WIDTH, default 24, coefficient width and fractional bits of the accumulator.
REQ-003 The block SHALL have parameter CHANNELS, default 4, number of time-shared filter channels; legal values are 2 and 4.
REQ-004 The block SHALL have parameter DEFAULT_COEF, default 1, per-channel coefficient after reset.
REQ-005 The block SHALL have port clk  in  1  sole clock; all logic updates on its rising edge.
REQ-006 The block SHALL have port rst  in  1  reset; synchronous and active-high.
REQ-007 The block SHALL have port in_valid  in  CHANNELS  per-channel sample request.
REQ-008 The block SHALL have port in_ready  out  CHANNELS  per-channel grant; at most one bit is set.
REQ-009 The block SHALL have port in_data  in  CHANNELS*WIDTH  packed signed samples; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port cfg_we  in  1  coefficient write strobe.
REQ-011 The block SHALL have port cfg_clr  in  1  channel state clear strobe.
REQ-012 The block SHALL have port cfg_ch  in  log2(CHANNELS)  config target channel.
REQ-013 The block SHALL have port cfg_coef  in  COEFFICIENT_WIDTH  unsigned coefficient.
REQ-014 The block SHALL have port out_valid  out  1  one-cycle result strobe.
REQ-015 The block SHALL have port out_ch  out  log2(CHANNELS)  channel of the result.
REQ-016 The block SHALL have port out_data  out  WIDTH  signed filtered result.
REQ-017 The block SHALL have port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 Per channel, the block SHALL hold coef[c], acc[c] (signed, WIDTH+COEFFICIENT_WIDTH bits) and y[c] (signed, WIDTH bits); one shared multiplier SHALL serve all channels.
REQ-019 The FSM SHALL have the states IDLE, MAC and UPDATE, with the transitions IDLE->MAC on handshake, MAC->UPDATE unconditionally and UPDATE->IDLE unconditionally.
REQ-020 In IDLE, in_ready SHALL be combinationally one-hot for the first requesting channel, searching upward from rr_ptr with wrap; in MAC and UPDATE, in_ready SHALL be 0.
REQ-021 A handshake (in_valid[c] & in_ready[c]) SHALL latch x and c, and set rr_ptr to c+1 modulo CHANNELS.
REQ-022 In MAC, the block SHALL register prod = coef[c] * (x - y[c]), with the difference computed at WIDTH+1 bits and no overflow.
REQ-023 In UPDATE, the block SHALL compute acc_new = acc[c] + prod, wrapping two's complement at WIDTH+COEFFICIENT_WIDTH bits; it SHALL write acc[c] <= acc_new and y[c] <= acc_new >>> COEFFICIENT_WIDTH as an arithmetic shift.
REQ-024 At the UPDATE edge, the block SHALL register out_valid=1, out_ch=c and out_data=new y[c]; out_valid SHALL then be high for exactly one cycle.
REQ-025 Latency SHALL be 3 cycles: a handshake in cycle T SHALL produce out_valid in cycle T+3.
REQ-026 The IDLE cycle in which out_valid is high SHALL be able to accept the next handshake, giving a throughput of 1 sample per 3 cycles.
REQ-027 cfg_we SHALL write coef[cfg_ch] in any state; if it targets the active channel during MAC, MAC SHALL use the old coefficient.
REQ-028 cfg_clr SHALL zero acc[cfg_ch] and y[cfg_ch] in any state; if it coincides with UPDATE of the same channel, the clear SHALL win, and out_data SHALL still carry the computed value.
REQ-029 If cfg_we and cfg_clr are both high, both actions SHALL apply.
REQ-030 A channel SHALL not be granted twice while another channel holds in_valid continuously, which follows from the round-robin rule.

Reset
REQ-031 While rst=1, the block SHALL set state=IDLE, rr_ptr=0, out_valid=0, out_ch=0, out_data=0, all acc=0, all y=0 and all coef=DEFAULT_COEF; in_ready SHALL be 0 during reset.
REQ-032 A reset asserted mid-operation (MAC or UPDATE) SHALL abort the sample, and the block SHALL emit no out_valid for it.

Verification
REQ-033 The bench SHALL cover: coef[0]=2^23, ch0 x=1000 twice -> out_data=500 then 750, out_ch=0, each at handshake+3.
REQ-034 The bench SHALL cover: coef[1]=2^23, fresh ch1 x=-1000 -> out_data=-500 (arithmetic shift check).
REQ-035 The bench SHALL cover: after reset, all in_valid held high -> grant order 0,1,2,3,0, one handshake every 3 cycles, in_ready one-hot.
REQ-036 The bench SHALL cover: cfg_we to ch0 with 2^22 during ch0 MAC (coef 2^23, x=1000) -> result 500; the next sample uses 2^22.
REQ-037 The bench SHALL cover: cfg_clr ch2 coincident with ch2 UPDATE -> out_data is the computed value; the next ch2 sample x=1000 with coef 2^23 -> 500.
REQ-038 The bench SHALL cover: rst asserted in MAC -> no out_valid; all outputs 0, coef=DEFAULT_COEF, and the next grant goes to the lowest requesting channel.

Source files
------------

// File: rtl/lag_filter_sched.sv
// Time-shared first-order lag filter: y += coef * (x - y) / 2^COEFFICIENT_WIDTH per channel,
// one shared multiplier, round-robin arbitration, 3-cycle latency, one sample per 3 cycles.
module lag_filter_sched #(
  parameter int WIDTH             = 24,
  parameter int COEFFICIENT_WIDTH = 24,
  parameter int CHANNELS          = 4,
  parameter int DEFAULT_COEF      = 1,
  localparam int CHW              = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic                         cfg_we,
  input  logic                         cfg_clr,
  input  logic [CHW-1:0]               cfg_ch,
  input  logic [COEFFICIENT_WIDTH-1:0] cfg_coef,
  output logic                         out_valid,
  output logic [CHW-1:0]               out_ch,
  output logic signed [WIDTH-1:0]      out_data,
  output logic                         busy
);
  localparam int ACCW = WIDTH + COEFFICIENT_WIDTH;

  typedef enum logic [1:0] {IDLE, MAC, UPDATE} state_t;

  state_t                       state;
  logic [CHW-1:0]               rr_ptr;
  logic [CHW-1:0]               cur_ch;
  logic [CHW-1:0]               grant_ch;
  logic                         grant_found;
  logic                         handshake;
  logic signed [WIDTH-1:0]      x_reg;
  logic signed [ACCW-1:0]       prod;
  logic [COEFFICIENT_WIDTH-1:0] coef [CHANNELS];
  logic signed [ACCW-1:0]       acc  [CHANNELS];
  logic signed [WIDTH-1:0]      y    [CHANNELS];

  logic signed [WIDTH:0]        diff;
  logic signed [ACCW-1:0]       prod_next;
  logic signed [ACCW-1:0]       acc_new;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [CHW-1:0] idx;
    idx         = '0;
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = rr_ptr + CHW'(k);
      if (!grant_found && in_valid[idx]) begin
        grant_found = 1'b1;
        grant_ch    = idx;
      end
    end
  end

  assign in_ready  = (state == IDLE && !rst && grant_found) ? (CHANNELS'(1) << grant_ch) : '0;
  assign handshake = |(in_valid & in_ready);
  assign busy      = (state != IDLE);

  // Difference is one bit wider so it can never overflow; coefficient is unsigned.
  assign diff      = {x_reg[WIDTH-1], x_reg} - {y[cur_ch][WIDTH-1], y[cur_ch]};
  assign prod_next = $signed({{WIDTH{1'b0}}, coef[cur_ch]}) * ACCW'(diff);
  assign acc_new   = acc[cur_ch] + prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_ch    <= '0;
      x_reg     <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]  <= '0;
        y[i]    <= '0;
        coef[i] <= COEFFICIENT_WIDTH'(DEFAULT_COEF);
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            x_reg  <= in_data[grant_ch*WIDTH +: WIDTH];
            cur_ch <= grant_ch;
            rr_ptr <= grant_ch + CHW'(1);
            state  <= MAC;
          end
        end
        MAC: begin
          prod  <= prod_next;
          state <= UPDATE;
        end
        UPDATE: begin
          // The top WIDTH bits are exactly acc_new >>> COEFFICIENT_WIDTH.
          acc[cur_ch] <= acc_new;
          y[cur_ch]   <= acc_new[ACCW-1:COEFFICIENT_WIDTH];
          out_valid   <= 1'b1;
          out_ch      <= cur_ch;
          out_data    <= acc_new[ACCW-1:COEFFICIENT_WIDTH];
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Placed after the datapath so a coincident clear overrides the update.
      if (cfg_we) coef[cfg_ch] <= cfg_coef;
      if (cfg_clr) begin
        acc[cfg_ch] <= '0;
        y[cfg_ch]   <= '0;
      end
    end
  end
endmodule
